// File: rtl/echo_delay_line.sv
// Sample-indexed circular-buffer delay with bypass, pure delay, feed-forward and feedback echo.
// The delay depth, the gain and the mode are set at runtime through the config port.
module echo_delay_line #(
  parameter int DATA_WIDTH = 32,
  parameter int DELAY_MAX  = 256,
  parameter int GAIN_WIDTH = 8,
  parameter int GAIN_FRAC  = 7,
  parameter int DLY_W      = $clog2(DELAY_MAX + 1)
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_cfg_valid,
  input  logic [DLY_W-1:0]      i_cfg_delay,
  input  logic [GAIN_WIDTH-1:0] i_cfg_gain,
  input  logic [1:0]            i_cfg_mode,
  input  logic                  i_valid,
  input  logic [DATA_WIDTH-1:0] i_data,
  output logic                  o_valid,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_sat,
  output logic                  o_cfg_err
);

  localparam int PTR_W  = $clog2(DELAY_MAX);
  localparam int ADDR_W = DLY_W + 1;
  localparam int PROD_W = DATA_WIDTH + GAIN_WIDTH;
  localparam int SUM_W  = PROD_W + 1;

  localparam logic [DATA_WIDTH-1:0] SAT_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
  localparam logic [DATA_WIDTH-1:0] SAT_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [DLY_W-1:0]      fill_q, fill_d;
  logic [DLY_W-1:0]      delay_q, delay_d;
  logic [GAIN_WIDTH-1:0] gain_q, gain_d;
  logic [1:0]            mode_q, mode_d;
  logic                  valid_q, valid_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  sat_q, sat_d;
  logic                  cfg_err_q, cfg_err_d;

  logic [DATA_WIDTH-1:0] buf_mem [DELAY_MAX];

  logic [ADDR_W-1:0]        wr_ext, dly_ext;
  logic [PTR_W-1:0]         rd_addr;
  logic [DATA_WIDTH-1:0]    delayed;
  logic signed [PROD_W-1:0] prod, shifted;
  logic signed [SUM_W-1:0]  sum;
  logic [SUM_W-DATA_WIDTH:0] sum_upper;
  logic                     ovf;
  logic [DATA_WIDTH-1:0]    echo_y, y, wr_data;
  logic                     y_sat, cfg_ok;

  // Read address sits D samples behind the write pointer, modulo the buffer depth.
  always_comb begin
    wr_ext  = ADDR_W'(wr_ptr_q);
    dly_ext = ADDR_W'(delay_q);
    if (wr_ext >= dly_ext) begin
      rd_addr = PTR_W'(wr_ext - dly_ext);
    end else begin
      rd_addr = PTR_W'(wr_ext + ADDR_W'(DELAY_MAX) - dly_ext);
    end
  end

  always_comb begin
    delayed   = (fill_q >= delay_q) ? buf_mem[rd_addr] : '0;
    prod      = $signed({{GAIN_WIDTH{delayed[DATA_WIDTH-1]}}, delayed})
              * $signed({{DATA_WIDTH{gain_q[GAIN_WIDTH-1]}}, gain_q});
    shifted   = prod >>> GAIN_FRAC;
    sum       = $signed({shifted[PROD_W-1], shifted})
              + $signed({{(SUM_W-DATA_WIDTH){i_data[DATA_WIDTH-1]}}, i_data});
    // Clipping is needed whenever the bits above the output sign bit disagree.
    sum_upper = sum[SUM_W-1:DATA_WIDTH-1];
    ovf       = !((&sum_upper) || !(|sum_upper));
    if (ovf) begin
      echo_y = sum[SUM_W-1] ? SAT_MIN : SAT_MAX;
    end else begin
      echo_y = sum[DATA_WIDTH-1:0];
    end
  end

  always_comb begin
    y     = i_data;
    y_sat = 1'b0;
    case (mode_q)
      2'd0: y = i_data;
      2'd1: y = delayed;
      default: begin
        y     = echo_y;
        y_sat = ovf;
      end
    endcase
    wr_data = (mode_q == 2'd3) ? y : i_data;
  end

  always_comb begin
    cfg_ok    = i_cfg_valid && (i_cfg_delay != '0) && (i_cfg_delay <= DLY_W'(DELAY_MAX));
    cfg_err_d = i_cfg_valid && !cfg_ok;
    delay_d   = delay_q;
    gain_d    = gain_q;
    mode_d    = mode_q;
    fill_d    = fill_q;
    wr_ptr_d  = wr_ptr_q;
    valid_d   = i_valid;
    data_d    = data_q;
    sat_d     = sat_q;
    if (i_valid) begin
      data_d   = y;
      sat_d    = y_sat;
      wr_ptr_d = (wr_ptr_q == PTR_W'(DELAY_MAX - 1)) ? '0 : wr_ptr_q + 1'b1;
      if (fill_q < DLY_W'(DELAY_MAX)) begin
        fill_d = fill_q + 1'b1;
      end
    end
    // A config accepted alongside a sample takes effect from the next sample.
    if (cfg_ok) begin
      delay_d = i_cfg_delay;
      gain_d  = i_cfg_gain;
      mode_d  = i_cfg_mode;
      fill_d  = '0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr_q  <= '0;
      fill_q    <= '0;
      delay_q   <= DLY_W'(1);
      gain_q    <= '0;
      mode_q    <= 2'd1;
      valid_q   <= 1'b0;
      data_q    <= '0;
      sat_q     <= 1'b0;
      cfg_err_q <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      fill_q    <= fill_d;
      delay_q   <= delay_d;
      gain_q    <= gain_d;
      mode_q    <= mode_d;
      valid_q   <= valid_d;
      data_q    <= data_d;
      sat_q     <= sat_d;
      cfg_err_q <= cfg_err_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_valid && !i_rst) begin
      buf_mem[wr_ptr_q] <= wr_data;
    end
  end

  assign o_valid   = valid_q;
  assign o_data    = data_q;
  assign o_sat     = sat_q;
  assign o_cfg_err = cfg_err_q;

endmodule

// File: tb/tb_echo_delay_line.sv
// Directed bench for echo_delay_line: hand-computed expected outputs for every mode,
// config rejection, maximum delay across the pointer wrap, and mid-stream reset.
module tb_echo_delay_line;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        i_cfg_valid = 1'b0;
  logic [8:0]  i_cfg_delay = '0;
  logic [7:0]  i_cfg_gain = '0;
  logic [1:0]  i_cfg_mode = '0;
  logic        i_valid = 1'b0;
  logic [31:0] i_data = '0;
  logic        o_valid;
  logic [31:0] o_data;
  logic        o_sat;
  logic        o_cfg_err;

  int          vec_count = 0;
  int          miss_count = 0;
  logic [31:0] last_d = '0;
  logic        last_s = 1'b0;

  echo_delay_line #(
    .DATA_WIDTH(32),
    .DELAY_MAX(256),
    .GAIN_WIDTH(8),
    .GAIN_FRAC(7)
  ) dut (
    .i_clk(i_clk),
    .i_rst(i_rst),
    .i_cfg_valid(i_cfg_valid),
    .i_cfg_delay(i_cfg_delay),
    .i_cfg_gain(i_cfg_gain),
    .i_cfg_mode(i_cfg_mode),
    .i_valid(i_valid),
    .i_data(i_data),
    .o_valid(o_valid),
    .o_data(o_data),
    .o_sat(o_sat),
    .o_cfg_err(o_cfg_err)
  );

  always #5 i_clk = ~i_clk;

  // Drives one cycle of inputs just after a rising edge and returns 1ns after the next one.
  task automatic applyStimulus(input logic v, input logic [31:0] x, input logic cv,
                               input logic [8:0] cd, input logic [7:0] cg, input logic [1:0] cm);
    i_valid     = v;
    i_data      = x;
    i_cfg_valid = cv;
    i_cfg_delay = cd;
    i_cfg_gain  = cg;
    i_cfg_mode  = cm;
    @(posedge i_clk);
    #1;
    i_valid     = 1'b0;
    i_cfg_valid = 1'b0;
  endtask

  task automatic checkOutput(input string tag, input logic exp_v, input logic [31:0] exp_d,
                             input logic exp_s);
    vec_count++;
    assert (o_valid === exp_v && o_data === exp_d && o_sat === exp_s) else begin
      miss_count++;
      $error("[TB] FAIL %s: got valid=%0b data=%h sat=%0b, expected valid=%0b data=%h sat=%0b",
             tag, o_valid, o_data, o_sat, exp_v, exp_d, exp_s);
    end
  endtask

  task automatic checkFlag(input string tag, input logic obs, input logic exp);
    vec_count++;
    assert (obs === exp) else begin
      miss_count++;
      $error("[TB] FAIL %s: got %0b, expected %0b", tag, obs, exp);
    end
  endtask

  task automatic sendSample(input string tag, input logic [31:0] x, input logic [31:0] exp_d,
                            input logic exp_s);
    applyStimulus(1'b1, x, 1'b0, '0, '0, '0);
    checkOutput(tag, 1'b1, exp_d, exp_s);
    last_d = exp_d;
    last_s = exp_s;
  endtask

  task automatic idleCycles(input int n);
    for (int k = 0; k < n; k++) begin
      applyStimulus(1'b0, 32'hDEAD_BEEF, 1'b0, '0, '0, '0);
      checkOutput("idle_hold", 1'b0, last_d, last_s);
    end
  endtask

  task automatic doConfig(input logic [8:0] d, input logic [7:0] g, input logic [1:0] m,
                          input logic exp_err);
    applyStimulus(1'b0, '0, 1'b1, d, g, m);
    checkFlag("cfg_err_pulse", o_cfg_err, exp_err);
    applyStimulus(1'b0, '0, 1'b0, '0, '0, '0);
    checkFlag("cfg_err_clear", o_cfg_err, 1'b0);
  endtask

  initial begin
    logic [31:0] ramp_exp;
    int gaps [8];
    gaps = '{0, 1, 2, 3, 0, 1, 2, 3};

    // Reset state
    repeat (2) @(posedge i_clk);
    #1;
    i_rst = 1'b0;
    checkOutput("reset_outputs", 1'b0, 32'd0, 1'b0);
    checkFlag("reset_cfg_err", o_cfg_err, 1'b0);

    // Defaults: D=1 pure delay
    sendSample("default_0", 32'd1, 32'd0, 1'b0);
    sendSample("default_1", 32'd2, 32'd1, 1'b0);
    sendSample("default_2", 32'd3, 32'd2, 1'b0);

    // Gapped pure delay, D=4
    doConfig(9'd4, 8'd0, 2'd1, 1'b0);
    for (int i = 0; i < 8; i++) begin
      sendSample("gapped_delay", 32'(10 + i), (i < 4) ? 32'd0 : 32'(10 + i - 4), 1'b0);
      idleCycles(gaps[i]);
    end

    // Feed-forward echo, D=2, gain 0.5
    doConfig(9'd2, 8'd64, 2'd2, 1'b0);
    sendSample("ff_0", 32'd100, 32'd100, 1'b0);
    sendSample("ff_1", 32'd0, 32'd0, 1'b0);
    sendSample("ff_2", 32'd0, 32'd50, 1'b0);
    sendSample("ff_3", 32'd0, 32'd0, 1'b0);
    sendSample("ff_neg_0", -32'sd3, -32'sd3, 1'b0);
    sendSample("ff_neg_1", 32'd0, 32'd0, 1'b0);
    sendSample("ff_neg_floor", 32'd0, -32'sd2, 1'b0);

    // Feedback echo, D=1, gain 0.5
    doConfig(9'd1, 8'd64, 2'd3, 1'b0);
    sendSample("fb_0", 32'd128, 32'd128, 1'b0);
    sendSample("fb_1", 32'd0, 32'd64, 1'b0);
    sendSample("fb_2", 32'd0, 32'd32, 1'b0);
    sendSample("fb_3", 32'd0, 32'd16, 1'b0);
    sendSample("fb_4", 32'd0, 32'd8, 1'b0);

    // Saturation, D=1, gain 127/128
    doConfig(9'd1, 8'd127, 2'd2, 1'b0);
    sendSample("sat_pos_0", 32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b0);
    sendSample("sat_pos_1", 32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b1);
    sendSample("sat_mixed", 32'h8000_0000, 32'hFEFF_FFFF, 1'b0);
    sendSample("sat_neg", 32'h8000_0000, 32'h8000_0000, 1'b1);

    // Bypass
    doConfig(9'd1, 8'd127, 2'd0, 1'b0);
    sendSample("bypass", 32'd55, 32'd55, 1'b0);

    // Rejected configs leave bypass in place
    doConfig(9'd0, 8'd64, 2'd1, 1'b1);
    sendSample("rej_d0_keep", 32'd77, 32'd77, 1'b0);
    doConfig(9'd257, 8'd64, 2'd1, 1'b1);
    sendSample("rej_d257_keep", 32'd78, 32'd78, 1'b0);

    // Config with a simultaneous sample: the sample still sees bypass
    applyStimulus(1'b1, 32'd500, 1'b1, 9'd1, 8'd0, 2'd1);
    checkOutput("same_cycle_old_cfg", 1'b1, 32'd500, 1'b0);
    checkFlag("same_cycle_no_err", o_cfg_err, 1'b0);
    last_d = 32'd500;
    last_s = 1'b0;
    sendSample("same_cycle_fill_clear", 32'd501, 32'd0, 1'b0);
    sendSample("same_cycle_new_cfg", 32'd502, 32'd501, 1'b0);

    // Maximum delay with a ramp, crossing the pointer wrap
    doConfig(9'd256, 8'd0, 2'd1, 1'b0);
    for (int i = 0; i < 300; i++) begin
      ramp_exp = (i < 256) ? 32'd0 : 32'(1000 + i - 256);
      sendSample("ramp_dmax", 32'(1000 + i), ramp_exp, 1'b0);
    end

    // Reset mid-stream drops the sample in the reset cycle
    doConfig(9'd2, 8'd0, 2'd1, 1'b0);
    sendSample("pre_rst_0", 32'd1, 32'd0, 1'b0);
    sendSample("pre_rst_1", 32'd2, 32'd0, 1'b0);
    sendSample("pre_rst_2", 32'd3, 32'd1, 1'b0);
    i_rst = 1'b1;
    applyStimulus(1'b1, 32'd99, 1'b0, '0, '0, '0);
    i_rst = 1'b0;
    checkOutput("mid_rst_outputs", 1'b0, 32'd0, 1'b0);
    last_d = 32'd0;
    last_s = 1'b0;
    sendSample("post_rst_0", 32'd7, 32'd0, 1'b0);
    sendSample("post_rst_1", 32'd8, 32'd7, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miss_count);
    $finish;
  end

endmodule

// File: doc/echo_delay_line.md
# echo_delay_line

Parametrised, sample-indexed delay and echo unit for the audio/stream datapath. It replaces the fixed-tap, clock-counted delay with a circular buffer whose depth is set at runtime over a configuration port. It can bypass, delay, or mix the delayed sample into the live input, either feed-forward or with feedback, using a signed fractional gain and saturating arithmetic. It sits between a stream source and the downstream sink, and both sides use valid-only handshakes with no backpressure.

## Interface
- DATA_WIDTH, 32, signed sample width
- DELAY_MAX, 256, maximum delay in samples; buffer depth; any value ≥ 2
- GAIN_WIDTH, 8, signed gain width
- GAIN_FRAC, 7, fractional bits of gain (Q format; 64 = 0.5 with defaults)
- DLY_W, $clog2(DELAY_MAX+1), derived; width of delay config
- i_clk  in  1  clock; all logic on rising edge
- i_rst  in  1  reset, synchronous, active-high (reset i_rst, synchronous, active-high; clock i_clk)
- i_cfg_valid  in  1  config strobe; single-cycle
- i_cfg_delay  in  DLY_W  delay D in samples, legal 1..DELAY_MAX
- i_cfg_gain  in  GAIN_WIDTH  signed echo gain
- i_cfg_mode  in  2  0 bypass, 1 pure delay, 2 feed-forward echo, 3 feedback echo
- i_valid  in  1  input sample strobe
- i_data  in  DATA_WIDTH  signed input sample x
- o_valid  out  1  output sample strobe
- o_data  out  DATA_WIDTH  signed output sample y
- o_sat  out  1  y was clipped this sample; qualified by o_valid
- o_cfg_err  out  1  one-cycle pulse: rejected config

## Operation
- Buffer: DELAY_MAX × DATA_WIDTH array and write pointer wr_ptr in 0..DELAY_MAX-1. The pointer advances only on i_valid and wraps to 0 after DELAY_MAX-1. Buffer contents are not reset.
- Read address: wr_ptr-D if wr_ptr ≥ D, else wr_ptr+DELAY_MAX-D. The read returns contents before this cycle's write (read-first). This matters at D = DELAY_MAX, where the read and write addresses are equal.
- Fill counter: increments on each i_valid and saturates at DELAY_MAX. The delayed sample d = buffer[read addr] if fill ≥ D, else 0.
- Modes, per valid sample:
  - 0 (bypass): y = x.
  - 1 (pure delay): y = d.
  - 2 (feed-forward echo): y = sat(x + ((d·g) >>> GAIN_FRAC)).
  - 3 (feedback echo): same formula as mode 2, but the buffer stores y instead of x. Modes 0–2 store x.
- Arithmetic:
  - Product is full width, DATA_WIDTH+GAIN_WIDTH signed.
  - Arithmetic right shift truncates toward −∞.
  - The sum is extended by 1 bit, then saturated to [−2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)−1].
  - o_sat=1 when clipping occurred; o_sat is always 0 in modes 0 and 1.
- Config:
  - Accepted when i_cfg_valid and 1 ≤ i_cfg_delay ≤ DELAY_MAX. Accepting a config latches delay, gain and mode and clears the fill counter, so history reads as zero. wr_ptr is unchanged.
  - Rejected otherwise: o_cfg_err pulses the next cycle and the stored config is unchanged. The gain and mode fields are ignored too.
- Simultaneous i_cfg_valid and i_valid: the sample is processed with the old config and written to the buffer. The new config, including the fill clear, applies from the next sample. The fill clear wins over that sample's increment.
- Defaults after reset: D=1, gain=0, mode=1, fill=0, wr_ptr=0.

## Timing
- Latency is 1 cycle: o_valid is i_valid registered, and o_data/o_sat are registered in the same cycle.
- Invalid input cycles produce o_valid=0 and do not advance the pointer or fill. The delay counts samples, not clocks.
- While o_valid=0, o_data and o_sat hold their last values.
- Reset values: o_valid=0, o_data=0, o_sat=0, o_cfg_err=0.
- Reset mid-stream: an i_valid in the reset cycle is dropped. The first post-reset outputs in mode 1 are 0 until D samples have been written.
- Throughput: one sample per clock sustained.

## Test plan
- Defaults: reset, then i_data 1,2,3 on consecutive cycles -> o_data 0,1,2, each one cycle after its input; o_sat=0.
- Gapped delay: cfg D=4 mode 1, then inputs 10..17 with 0–3 idle cycles between them -> o_data 0,0,0,0,10,11,12,13; o_valid count equals the i_valid count.
- Feed-forward: cfg D=2 gain=64 mode 2, then inputs 100,0,0,0 -> 100,0,50,0. With input −3 followed by zeros, the output two samples later is −2 (floor).
- Feedback: cfg D=1 gain=64 mode 3, then inputs 128,0,0,0,0 -> 128,64,32,16,8.
- Saturation: mode 2, D=1, gain=127, inputs 0x7FFFFFFF twice -> second y=0x7FFFFFFF with o_sat=1. Inputs 0x80000000 twice -> second y=0x80000000 with o_sat=1.
- Config edges:
  - D=0 and D=DELAY_MAX+1 -> o_cfg_err pulse and unchanged behaviour.
  - D=DELAY_MAX with a ramp input -> output equals input−DELAY_MAX after fill, correct across the wrap.
  - Config in the same cycle as a sample -> that sample uses the old config.
  - Reset mid-stream -> output restarts from 0.
